seven_seg_reader: RTL and testbench

Inverse of the board's 7-segment encoder: watches an active-low 7-bit segment bus, filters glitches, and decodes each newly settled pattern back to its 4-bit digit. Decoded digits go through a 2-entry valid/ready FIFO; blank and illegal patterns are flagged. It sits on the display path of the Simon Says top level, where it loops displayed digits back into the game checker and self-test logic.

---
 rtl/seven_seg_reader.sv | 154 +++++++++++++++
 tb/tb_seven_seg_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader.sv
// Decodes a glitch-filtered active-low 7-segment bus back to 4-bit digits.
// Digits go out through a 2-entry valid/ready FIFO; blank and illegal patterns are flagged.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       hex,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             blank,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [6:0]       BLANK   = 7'b1111111;

  typedef enum logic {TRACK, HELD} state_t;

  logic [6:0]       r_hex_q;
  logic [CNT_W-1:0] r_run_cnt;
  logic [6:0]       r_settled_q;
  state_t           r_state;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  logic [3:0]       r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_overrun;

  logic             w_legal;
  logic [3:0]       w_dec_digit;
  logic             w_settle;
  logic             w_is_blank;
  logic             w_push;
  logic             w_illegal_settle;
  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;

  always_comb begin
    w_legal     = 1'b1;
    w_dec_digit = 4'd0;
    case (r_hex_q)
      7'b1000000: w_dec_digit = 4'd0;
      7'b1111001: w_dec_digit = 4'd1;
      7'b0100100: w_dec_digit = 4'd2;
      7'b0110000: w_dec_digit = 4'd3;
      7'b0011001: w_dec_digit = 4'd4;
      7'b0010010: w_dec_digit = 4'd5;
      7'b0000010: w_dec_digit = 4'd6;
      7'b1111000: w_dec_digit = 4'd7;
      7'b0000000: w_dec_digit = 4'd8;
      7'b0010000: w_dec_digit = 4'd9;
      default:    w_legal     = 1'b0;
    endcase
  end

  // Run length of the current sampled pattern, saturating at the settle threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex_q   <= BLANK;
      r_run_cnt <= '0;
    end else begin
      r_hex_q <= hex;
      if (hex != r_hex_q)
        r_run_cnt <= CNT_W'(1);
      else if (r_run_cnt != CNT_MAX)
        r_run_cnt <= r_run_cnt + CNT_W'(1);
    end
  end

  assign w_is_blank       = (r_hex_q == BLANK);
  assign w_settle         = (r_state == TRACK) && (r_run_cnt == CNT_MAX) && (r_hex_q != r_settled_q);
  assign w_push           = w_settle && w_legal;
  assign w_illegal_settle = w_settle && !w_legal && !w_is_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= TRACK;
      r_settled_q <= BLANK;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        TRACK: begin
          if (w_settle) begin
            r_settled_q <= r_hex_q;
            r_state     <= HELD;
            if (w_illegal_settle) begin
              r_err_pulse <= 1'b1;
              if (r_err_count != {ERR_W{1'b1}})
                r_err_count <= r_err_count + ERR_W'(1);
            end
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_pop   = (r_count != 2'd0) && digit_ready;
  assign w_full  = (r_count == 2'd2);
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop)
        r_overrun <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (reset)
          r_mem[gi] <= 4'd0;
        else if (w_wr_en && (r_wr_ptr == 1'(gi)))
          r_mem[gi] <= w_dec_digit;
      end
    end
  endgenerate

  assign digit       = r_mem[r_rd_ptr];
  assign digit_valid = (r_count != 2'd0);
  assign blank       = (r_settled_q == BLANK);
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_seven_seg_reader;

  localparam int N     = 4;
  localparam int ERR_W = 2;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ILL   = 7'b0101010;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       hex;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             digit_ready;
  logic             blank;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             overrun;

  seven_seg_reader #(.STABLE_CYCLES(N), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .hex(hex), .digit(digit), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .blank(blank), .err_pulse(err_pulse),
    .err_count(err_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Segment codes for digits 0..9, active low, bit6 = g.
  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int lookup(logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (codes[i] == p) return i;
    return -1;
  endfunction

  // Reference model: settle when the last N samples agree and differ from the last settled pattern.
  logic [6:0] samples [$];
  int         m_q [$];
  logic [6:0] m_settled;
  bit         m_held, m_err_pulse, m_overrun, m_started;
  int         m_err_count;
  bit         m_settle, m_pop;
  int         m_idx;

  always @(posedge clk) begin
    if (reset) begin
      samples.delete();
      m_q.delete();
      m_settled   = BLANK;
      m_held      = 0;
      m_err_pulse = 0;
      m_overrun   = 0;
      m_err_count = 0;
      m_started   = 1;
    end else if (m_started) begin
      m_pop    = (m_q.size() > 0) && digit_ready;
      m_settle = 0;
      if (!m_held && samples.size() >= N) begin
        m_settle = 1;
        for (int i = 0; i < N; i++)
          if (samples[samples.size()-1-i] != samples[samples.size()-1]) m_settle = 0;
        if (samples[samples.size()-1] == m_settled) m_settle = 0;
      end
      m_held      = m_settle;
      m_err_pulse = 0;
      if (m_pop) void'(m_q.pop_front());
      if (m_settle) begin
        m_settled = samples[samples.size()-1];
        m_idx     = lookup(m_settled);
        if (m_idx >= 0) begin
          if (m_q.size() == 2) m_overrun = 1;
          else m_q.push_back(m_idx);
        end else if (m_settled != BLANK) begin
          m_err_pulse = 1;
          if (m_err_count < (1 << ERR_W) - 1) m_err_count++;
        end
      end
      samples.push_back(hex);
      if (samples.size() > N) void'(samples.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("digit_valid", int'(digit_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) chk("digit", int'(digit), m_q[0]);
      chk("blank", int'(blank), int'(m_settled == BLANK));
      chk("err_pulse", int'(err_pulse), int'(m_err_pulse));
      chk("err_count", int'(err_count), m_err_count);
      chk("overrun", int'(overrun), int'(m_overrun));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle_to(logic [6:0] p);
    hex = p;
    tick(6);
  endtask

  initial begin
    reset = 1'b1; hex = BLANK; digit_ready = 1'b0;
    tick(2);
    reset = 1'b0;

    // Idle with blank held
    tick(20);
    chk("idle_valid", int'(digit_valid), 0);
    chk("idle_blank", int'(blank), 1);
    chk("idle_errcnt", int'(err_count), 0);

    // Digit 3 settles on the fifth edge and is consumed immediately
    digit_ready = 1'b1;
    hex = codes[3];
    tick(4);
    chk("pre_settle_valid", int'(digit_valid), 0);
    tick(1);
    chk("e5_valid", int'(digit_valid), 1);
    chk("e5_digit", int'(digit), 3);
    chk("e5_blank", int'(blank), 0);
    tick(1);
    chk("e6_valid", int'(digit_valid), 0);

    // Short glitch of 5 never settles
    hex = codes[5];
    tick(3);
    hex = BLANK;
    tick(8);
    chk("glitch_valid", int'(digit_valid), 0);
    chk("glitch_errcnt", int'(err_count), 0);
    chk("glitch_blank", int'(blank), 1);

    // Overrun: 1, 2 queued, 7 dropped
    digit_ready = 1'b0;
    settle_to(codes[1]); settle_to(BLANK);
    settle_to(codes[2]); settle_to(BLANK);
    settle_to(codes[7]);
    chk("ovr_valid", int'(digit_valid), 1);
    chk("ovr_head", int'(digit), 1);
    chk("ovr_flag", int'(overrun), 1);
    digit_ready = 1'b1;
    tick(1);
    chk("ovr_second", int'(digit), 2);
    tick(1);
    chk("ovr_drained", int'(digit_valid), 0);

    // Illegal patterns and counter saturation
    hex = ILL;
    tick(5);
    chk("ill_pulse", int'(err_pulse), 1);
    tick(1);
    chk("ill_pulse_end", int'(err_pulse), 0);
    settle_to(BLANK);
    settle_to(ILL);
    chk("ill_count2", int'(err_count), 2);
    chk("ill_nopush", int'(digit_valid), 0);
    for (int i = 0; i < 3; i++) begin
      settle_to(BLANK);
      settle_to(ILL);
    end
    chk("ill_sat", int'(err_count), 3);
    settle_to(BLANK);

    // Push and pop together while full
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    digit_ready = 1'b0;
    settle_to(codes[4]); settle_to(BLANK);
    settle_to(codes[5]); settle_to(BLANK);
    hex = codes[9];
    tick(4);
    digit_ready = 1'b1;
    tick(1);
    chk("pp_valid", int'(digit_valid), 1);
    chk("pp_head", int'(digit), 5);
    chk("pp_overrun", int'(overrun), 0);
    digit_ready = 1'b0;
    tick(2);
    chk("pp_stable", int'(digit), 5);
    digit_ready = 1'b1;
    tick(1);
    chk("pp_next", int'(digit), 9);
    tick(1);
    chk("pp_empty", int'(digit_valid), 0);

    // Reset mid-stream
    digit_ready = 1'b0;
    settle_to(codes[8]);
    hex = ILL;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("rst_valid", int'(digit_valid), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_errcnt", int'(err_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    hex = BLANK;
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
